// File: rtl/waterfall_writer_pkg.sv
// Shared constants and types for the waterfall writer.
// Framebuffer geometry and widths match the LCD driver and framebuffer RAM.
package waterfall_writer_pkg;

    localparam int FB_H_PIXELS = 320;   // pixels per row
    localparam int FB_V_LINES  = 240;   // rows in framebuffer
    localparam int FB_ADDR_W   = 17;    // 320*240-1 = 76799 fits 17 bits
    localparam int PIX_W       = 8;     // framebuffer pixel width
    localparam int ADC_W       = 12;    // ADC sample width
    localparam int ROW_W       = 8;     // row counter / row_base width

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/waterfall_writer_if.sv
// Bus between ADC/arbiter side and the waterfall writer.
//   adc_ready/adc_data : sample strobe + unsigned sample
//   wr_allow           : RAM port free for a writer access next cycle
//   ram_addr/wdata/we  : framebuffer write port
//   row_base           : oldest complete row, for display scrolling
//   overflow           : sticky pixel-drop flag
// master = the side that feeds samples and grants the RAM; slave = the writer.
interface waterfall_writer_if;
    import waterfall_writer_pkg::*;

    logic                 adc_ready;
    logic [ADC_W-1:0]     adc_data;
    logic                 wr_allow;
    logic [FB_ADDR_W-1:0] ram_addr;
    logic [PIX_W-1:0]     ram_wdata;
    logic                 ram_we;
    logic [ROW_W-1:0]     row_base;
    logic                 overflow;

    modport master (
        output adc_ready, adc_data, wr_allow,
        input  ram_addr, ram_wdata, ram_we, row_base, overflow
    );

    modport slave (
        input  adc_ready, adc_data, wr_allow,
        output ram_addr, ram_wdata, ram_we, row_base, overflow
    );

endinterface

// File: rtl/waterfall_writer_sync_fifo.sv
// Small synchronous FIFO for decimated pixels.
//   clk, resetn : clock, async active-low reset (pointers only)
//   push, wdata : write request; dropped when full unless a pop happens the same cycle
//   pop         : read request, ignored when empty
//   head        : oldest entry, straight from the storage registers
//   full, empty : status
//   drop        : a push was refused this cycle
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written, so both are honoured.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/waterfall_writer.sv
// Waterfall writer: box-averages ADC samples, scales them to 8-bit intensity,
// buffers them and writes them raster-order into the framebuffer RAM.
//   clk, resetn : pixel clock, async active-low reset
//   bus (slave) : adc_ready/adc_data in, wr_allow in,
//                 ram_addr/ram_wdata/ram_we out, row_base out, overflow out
module waterfall_writer
    import waterfall_writer_pkg::*;
#(
    parameter int H_PIXELS     = FB_H_PIXELS,
    parameter int V_LINES      = FB_V_LINES,
    parameter int SAMPLE_WIDTH = ADC_W,
    parameter int DECIM_LOG2   = 2,
    parameter int GAIN_SHIFT   = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input logic               clk,
    input logic               resetn,
    waterfall_writer_if.slave bus
);
    localparam int ACC_W = SAMPLE_WIDTH + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int GW    = SAMPLE_WIDTH + GAIN_SHIFT;
    localparam int COL_W = $clog2(H_PIXELS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIXELS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_LINES - 1);

    // ---------------- decimator ----------------
    logic [ACC_W-1:0]        acc, sum;
    logic [CNT_W-1:0]        cnt;
    logic [SAMPLE_WIDTH-1:0] avg, sat;
    logic [GW-1:0]           gained;
    logic [PIX_W-1:0]        pix;
    logic                    push;

    always_comb begin
        sum    = acc + ACC_W'(bus.adc_data);
        avg    = SAMPLE_WIDTH'(sum >> DECIM_LOG2);
        gained = GW'(avg) << GAIN_SHIFT;
        // Anything shifted past the sample width saturates to full scale.
        sat    = ((gained >> SAMPLE_WIDTH) != '0) ? '1 : gained[SAMPLE_WIDTH-1:0];
    end

    // The completing sample goes straight into the finished pixel; the pixel
    // is pushed the following cycle while accumulation carries on from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc  <= '0;
            cnt  <= '0;
            pix  <= '0;
            push <= 1'b0;
        end else begin
            push <= 1'b0;
            if (bus.adc_ready) begin
                if (cnt == CNT_LAST) begin
                    acc  <= '0;
                    cnt  <= '0;
                    pix  <= sat[SAMPLE_WIDTH-1 -: PIX_W];
                    push <= 1'b1;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- pixel FIFO ----------------
    logic             pop, full, empty, drop;
    logic [PIX_W-1:0] head;

    sync_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (pix),
        .pop    (pop),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .drop   (drop)
    );

    // ---------------- write FSM ----------------
    wr_state_e state, state_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // A pop in either state produces the write one cycle later; chaining
    // from WRITE gives one pixel per cycle while wr_allow holds.
    always_comb begin
        pop       = 1'b0;
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE, ST_WRITE: begin
                if (bus.wr_allow && !empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.ram_we = (state == ST_WRITE);

    // ---------------- address counters ----------------
    // row_addr tracks row*H_PIXELS incrementally, avoiding a multiplier.
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [FB_ADDR_W-1:0] row_addr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col           <= '0;
            row           <= '0;
            row_addr      <= '0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.row_base  <= '0;
            bus.overflow  <= 1'b0;
        end else begin
            if (pop) begin
                bus.ram_addr  <= row_addr + FB_ADDR_W'(col);
                bus.ram_wdata <= head;
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row      <= '0;
                        row_addr <= '0;
                    end else begin
                        row      <= row + 1'b1;
                        row_addr <= row_addr + FB_ADDR_W'(H_PIXELS);
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
            // row moves on the pop of a row's last pixel, so row_base follows
            // one cycle after that pixel's write strobe.
            bus.row_base <= row;
            if (drop) bus.overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_waterfall_writer.sv
module tb_waterfall_writer;
    import waterfall_writer_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    waterfall_writer_if if_a();
    waterfall_writer_if if_b();

    // Full geometry, 4:1 averaging, unity gain.
    waterfall_writer #(.DECIM_LOG2(2), .GAIN_SHIFT(0)) dut_a (
        .clk(clk), .resetn(resetn), .bus(if_a)
    );
    // Tiny 8x4 frame, no decimation, gain x4 (saturation and frame wrap).
    waterfall_writer #(.H_PIXELS(8), .V_LINES(4), .DECIM_LOG2(0), .GAIN_SHIFT(2)) dut_b (
        .clk(clk), .resetn(resetn), .bus(if_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- write monitor ----------------
    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [PIX_W-1:0]     data;
    } wr_t;

    wr_t q_a[$], q_b[$], exp_a[$], exp_b[$];
    int  run_a = 0, max_run_a = 0;
    logic prev_last_a = 0, prev_last_b = 0;
    logic [7:0] rb_at_last_a = 8'hEE, rb_after_last_a = 8'hEE;
    logic [7:0] rb_at_last_b = 8'hEE, rb_after_last_b = 8'hEE;

    always @(negedge clk) begin
        if (prev_last_a) rb_after_last_a = if_a.row_base;
        if (prev_last_b) rb_after_last_b = if_b.row_base;
        prev_last_a = 0;
        prev_last_b = 0;
        if (if_a.ram_we === 1'b1) begin
            q_a.push_back({if_a.ram_addr, if_a.ram_wdata});
            run_a++;
            if (run_a > max_run_a) max_run_a = run_a;
            if (if_a.ram_addr == 17'd319) begin
                rb_at_last_a = if_a.row_base;
                prev_last_a  = 1;
            end
        end else begin
            run_a = 0;
        end
        if (if_b.ram_we === 1'b1) begin
            q_b.push_back({if_b.ram_addr, if_b.ram_wdata});
            if (if_b.ram_addr == 17'd31) begin
                rb_at_last_b = if_b.row_base;
                prev_last_b  = 1;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_pix(input int sum, input int dlog, input int gain);
        int v;
        v = (sum >> dlog) << gain;
        if (v > 4095) v = 4095;
        return 8'(v >> 4);
    endfunction

    int nxt_a = 0, nxt_b = 0;

    // Four samples base..base+3 make one dut_a pixel.
    task automatic push_pixel_a(input int base_in, input logic allow, input bit expect_write);
        int base, sum;
        base = base_in & 12'hFFC;
        sum  = 0;
        for (int j = 0; j < 4; j++) begin
            if_a.adc_ready = 1'b1;
            if_a.adc_data  = 12'(base + j);
            if_a.wr_allow  = allow;
            sum += base + j;
            step();
        end
        if_a.adc_ready = 1'b0;
        if (expect_write) begin
            exp_a.push_back({17'(nxt_a), model_pix(sum, 2, 0)});
            nxt_a = (nxt_a + 1) % (320 * 240);
        end
    endtask

    task automatic push_pixel_b(input int s);
        if_b.adc_ready = 1'b1;
        if_b.adc_data  = 12'(s);
        step();
        if_b.adc_ready = 1'b0;
        exp_b.push_back({17'(nxt_b), model_pix(s & 12'hFFF, 0, 2)});
        nxt_b = (nxt_b + 1) % 32;
    endtask

    task automatic check_writes(input bit sel);
        wr_t g[$];
        wr_t e[$];
        if (sel) begin g = q_b; e = exp_b; q_b.delete(); exp_b.delete(); end
        else     begin g = q_a; e = exp_a; q_a.delete(); exp_a.delete(); end
        check(sel ? "b write count" : "a write count", g.size(), e.size());
        for (int i = 0; i < g.size() && i < e.size(); i++) begin
            check($sformatf("%s addr[%0d]", sel ? "b" : "a", i), 32'(g[i].addr), 32'(e[i].addr));
            check($sformatf("%s data[%0d]", sel ? "b" : "a", i), 32'(g[i].data), 32'(e[i].data));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rdy;
        logic [11:0] data;
        logic        allow;
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wdata;
    } vec_t;

    vec_t vt[13];

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if_a.adc_ready = vt[i].rdy;
            if_a.adc_data  = vt[i].data;
            if_a.wr_allow  = vt[i].allow;
            step();
            check($sformatf("vec%0d we", i),    32'(if_a.ram_we),    32'(vt[i].we));
            check($sformatf("vec%0d addr", i),  32'(if_a.ram_addr),  32'(vt[i].addr));
            check($sformatf("vec%0d wdata", i), 32'(if_a.ram_wdata), 32'(vt[i].wdata));
        end
        if_a.adc_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Decimation of 0x100..0x400: avg 0x280 -> 0x28, written two cycles after the 4th sample.
        vt[0]  = '{1, 12'h100, 1, 0, 17'd0, 8'h00};
        vt[1]  = '{1, 12'h200, 1, 0, 17'd0, 8'h00};
        vt[2]  = '{1, 12'h300, 1, 0, 17'd0, 8'h00};
        vt[3]  = '{1, 12'h400, 1, 0, 17'd0, 8'h00};
        vt[4]  = '{0, 12'h000, 1, 0, 17'd0, 8'h00};
        vt[5]  = '{0, 12'h000, 1, 1, 17'd0, 8'h28};
        vt[6]  = '{0, 12'h000, 1, 0, 17'd0, 8'h28};
        // wr_allow 1,0,1,0,1,1 with pixels 0x11,0x22,0x33 queued.
        vt[7]  = '{0, 12'h000, 1, 1, 17'd1, 8'h11};
        vt[8]  = '{0, 12'h000, 0, 0, 17'd1, 8'h11};
        vt[9]  = '{0, 12'h000, 1, 1, 17'd2, 8'h22};
        vt[10] = '{0, 12'h000, 0, 0, 17'd2, 8'h22};
        vt[11] = '{0, 12'h000, 1, 1, 17'd3, 8'h33};
        vt[12] = '{0, 12'h000, 1, 0, 17'd3, 8'h33};

        if_a.adc_ready = 0; if_a.adc_data = '0; if_a.wr_allow = 0;
        if_b.adc_ready = 0; if_b.adc_data = '0; if_b.wr_allow = 1;

        // Reset state
        repeat (3) step();
        check("rst a we",       32'(if_a.ram_we),    0);
        check("rst a addr",     32'(if_a.ram_addr),  0);
        check("rst a wdata",    32'(if_a.ram_wdata), 0);
        check("rst a row_base", 32'(if_a.row_base),  0);
        check("rst a overflow", 32'(if_a.overflow),  0);
        check("rst b we",       32'(if_b.ram_we),    0);
        resetn = 1'b1;
        step();

        // Test 1 and test 5 from the table
        apply_vecs(0, 6);
        push_pixel_a(12'h110, 0, 0);
        push_pixel_a(12'h220, 0, 0);
        push_pixel_a(12'h330, 0, 0);
        step();
        apply_vecs(7, 12);
        q_a.delete();
        nxt_a = 4;

        // Test 2: finish row 0 and write the first pixel of row 1
        for (int k = 0; k < 317; k++) push_pixel_a(k * 53, 1, 1);
        repeat (6) step();
        check_writes(0);
        check("row_base during pixel 319", 32'(rb_at_last_a),    0);
        check("row_base after pixel 319",  32'(rb_after_last_a), 1);
        check("row_base a now",            32'(if_a.row_base),   1);

        // Test 4: overflow and back-to-back drain
        check("overflow before", 32'(if_a.overflow), 0);
        for (int k = 0; k < 17; k++) push_pixel_a(k * 211 + 7, 0, k < 16);
        if_a.wr_allow = 0;
        step();
        check("overflow set", 32'(if_a.overflow), 1);
        check("no writes while blocked", q_a.size(), 0);
        max_run_a = 0;
        if_a.wr_allow = 1;
        repeat (20) step();
        check("burst length", 32'(max_run_a), 16);
        check_writes(0);
        check("overflow sticky", 32'(if_a.overflow), 1);

        // Test 6 saturation + test 3 frame wrap on the 8x4 instance
        push_pixel_b(12'hFFF);
        push_pixel_b(12'h100);
        for (int k = 2; k < 43; k++) push_pixel_b(k * 97 + 5);
        repeat (4) step();
        check_writes(1);
        check("row_base during last pixel", 32'(rb_at_last_b),    3);
        check("row_base after frame wrap",  32'(rb_after_last_b), 0);
        check("row_base b mid row 1",       32'(if_b.row_base),   1);

        // Reset mid-row: outputs clear without a clock edge
        resetn = 1'b0;
        #2;
        check("mid rst b addr",     32'(if_b.ram_addr),  0);
        check("mid rst b wdata",    32'(if_b.ram_wdata), 0);
        check("mid rst b we",       32'(if_b.ram_we),    0);
        check("mid rst b row_base", 32'(if_b.row_base),  0);
        check("mid rst a overflow", 32'(if_a.overflow),  0);
        check("mid rst a addr",     32'(if_a.ram_addr),  0);
        step();
        resetn = 1'b1;
        step();
        q_b.delete();
        exp_b.delete();
        nxt_b = 0;
        push_pixel_b(12'h123);
        repeat (4) step();
        check_writes(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
